tz_expander: RTL
================

Name: tz_expander

Overview:
- Inverse of the trailing-zero counter: accepts a stream of trailing-zero counts and expands each one into an LSB-first serial bitstream.
- For count N < DATA_WIDTH the block emits N zeros then a single '1'. For N == DATA_WIDTH it emits DATA_WIDTH zeros and no '1'.
- Sits between a count producer (e.g. a compressed bit-position FIFO) and a serial bit consumer.
- Both ends use valid/ready handshakes.

Parameters:
- DATA_WIDTH, 32, maximum symbol length in bits; a count of DATA_WIDTH encodes the all-zero word.
- CNT_W, $clog2(DATA_WIDTH)+1, width of the count input (derived, not overridden).

Ports:
- clk  input  1  clock; all logic on rising edge.
- resetn  input  1  synchronous active-low reset.
- din  input  CNT_W  trailing-zero count.
- din_valid  input  1  din holds a valid count.
- din_ready  output  1  block can accept din this cycle.
- dout  output  1  current serial bit.
- dout_valid  output  1  dout is valid.
- dout_ready  input  1  consumer takes dout this cycle.
- dout_last  output  1  dout is the final bit of the current symbol.
- err  output  1  one-cycle pulse: accepted count exceeded DATA_WIDTH.

Behaviour:
- Reset (resetn==0 at a clk edge):
  - state=IDLE.
  - din_ready=1 after reset; dout_valid, dout, dout_last, err all 0.
  - Reset mid-symbol abandons remaining bits; nothing is emitted afterwards.
- States:
  - IDLE: no symbol in progress.
  - ZEROS: emitting zeros; remaining-zero counter rem > 0.
  - ONE: emitting the terminating '1'.
- Accept: occurs when din_valid && din_ready.
  - Count c = min(din, DATA_WIDTH).
  - err=1 next cycle if din > DATA_WIDTH; the count saturates to DATA_WIDTH.
- Transitions on accept:
  - c==0: go to ONE.
  - c>0: go to ZEROS with rem=c.
- Output values:
  - ZEROS: dout=0, dout_valid=1, dout_last=(rem==1 && c_latched==DATA_WIDTH).
  - ONE: dout=1, dout_valid=1, dout_last=1.
  - IDLE: dout_valid=0.
- On dout_valid && dout_ready:
  - ZEROS, rem>1: rem decrements.
  - ZEROS, rem==1: go to ONE if c_latched<DATA_WIDTH, else end symbol.
  - ONE: end symbol.
- Symbol end: go to IDLE, unless a new count is accepted in the same cycle, in which case load it directly.
- Backpressure: with dout_ready=0, all of dout, dout_valid, dout_last and the state hold.
- din_ready = (state==IDLE) || (dout_valid && dout_ready && dout_last). This gives back-to-back symbols with no bubble.
- Latency: the first bit of an accepted count is valid the cycle after acceptance.
- Throughput: one bit per cycle when dout_ready=1. A symbol of count N takes N+1 bit-cycles (N<DATA_WIDTH), or DATA_WIDTH bit-cycles (N==DATA_WIDTH).
- Outputs are registered; there is no combinational path from din to dout.
- Output invariant: the bits of one symbol, LSB first, form a word whose trailing-zero count equals c.

Decomposition:
- Package tz_pkg holds:
  - CNT_W as a function of DATA_WIDTH.
  - state enum {IDLE, ZEROS, ONE}.
  - a saturating-clamp function for counts.
- No sub-module: one FSM plus a down-counter is sufficient.

Test Plan:
- Zero count: DATA_WIDTH=8, din=0 accepted, dout_ready=1 -> next cycle a single bit dout=1, dout_last=1; err=0.
- Mid-range count: din=3 -> four consecutive bits 0,0,0,1; dout_last only on the '1'; din_ready rises on the last bit.
- All-zero word: din=8 with DATA_WIDTH=8 -> eight zeros; dout_last on the 8th; no '1' emitted.
- Back-to-back: din_valid held with 2 then 0 -> stream 0,0,1,1 with no idle cycle between symbols.
- Backpressure: din=2, dout_ready low on cycles 2-4 -> dout, dout_valid, dout_last stable while low; total stream 0,0,1 unchanged.
- Overrange and reset:
  - din=12 with DATA_WIDTH=8 -> err pulses for 1 cycle; stream is eight zeros.
  - resetn low during the 4th zero -> next cycle dout_valid=0, din_ready=1; the next din=1 gives 0,1.

Source files
------------

// File: rtl/tz_pkg.sv
// Shared types and helpers for the trailing-zero expander.
package tz_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ZEROS = 2'd1,
    ONE   = 2'd2
  } state_t;

  // Count width able to hold 0..data_width inclusive.
  function automatic int cnt_width(input int data_width);
    return $clog2(data_width) + 1;
  endfunction

  function automatic int clamp_count(input int cnt, input int max_cnt);
    return (cnt > max_cnt) ? max_cnt : cnt;
  endfunction

endpackage

// File: rtl/tz_expander.sv
// Expands trailing-zero counts into LSB-first serial bitstreams (N zeros, then a '1'
// unless N equals DATA_WIDTH). Valid/ready on both sides; all outputs registered.
module tz_expander
  import tz_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int CNT_W      = cnt_width(DATA_WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [CNT_W-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             err
);

  localparam logic [CNT_W-1:0] DW_C = CNT_W'(DATA_WIDTH);

  state_t           state;
  logic [CNT_W-1:0] rem;
  logic             full;   // latched count was DATA_WIDTH: symbol ends without a '1'

  logic             fire;
  logic             accept;
  logic             overrange;
  logic [CNT_W-1:0] c_in;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    fire      = dout_valid && dout_ready;
    din_ready = (state == IDLE) || (fire && dout_last);
    accept    = din_valid && din_ready;
    overrange = din > DW_C;
    c_in      = CNT_W'(clamp_count(int'(din), DATA_WIDTH));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      rem        <= '0;
      full       <= 1'b0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= accept && overrange;

      if (accept) begin
        // A new count can only be taken when idle or on the last bit of the
        // previous symbol, so loading here never truncates a symbol.
        dout_valid <= 1'b1;
        if (c_in == '0) begin
          state     <= ONE;
          rem       <= '0;
          full      <= 1'b0;
          dout      <= 1'b1;
          dout_last <= 1'b1;
        end else begin
          state     <= ZEROS;
          rem       <= c_in;
          full      <= (c_in == DW_C);
          dout      <= 1'b0;
          dout_last <= (c_in == CNT_W'(1)) && (c_in == DW_C);
        end
      end else if (fire) begin
        unique case (state)
          ZEROS: begin
            if (rem > CNT_W'(1)) begin
              rem       <= rem - CNT_W'(1);
              dout_last <= (rem == CNT_W'(2)) && full;
            end else if (!full) begin
              state     <= ONE;
              rem       <= '0;
              dout      <= 1'b1;
              dout_last <= 1'b1;
            end else begin
              state      <= IDLE;
              rem        <= '0;
              full       <= 1'b0;
              dout_valid <= 1'b0;
              dout_last  <= 1'b0;
            end
          end
          ONE: begin
            state      <= IDLE;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
          end
          default: begin
            state      <= IDLE;
            dout_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
